// File: rtl/mini_dmem_arb_pkg.sv
// ============================================================================
// mini_dmem_arb_pkg : shared D_MEM request types, address map and constants
// Rev 1.0
// ============================================================================
`default_nettype none

package mini_dmem_arb_pkg;

  typedef enum logic {
    DMEM_RD = 1'b0,
    DMEM_WR = 1'b1
  } t_dmem_op;

  typedef logic [7:0] t_tile_id;

  typedef struct packed {
    logic        valid;
    t_dmem_op    op;
    logic [31:0] addr;
    logic [31:0] wrdata;
    logic [3:0]  byteen;
    t_tile_id    id;
  } t_dmem_req;

  typedef enum logic {
    SRC_CORE = 1'b0,
    SRC_FAB  = 1'b1
  } t_rd_src;

  typedef struct packed {
    logic     valid;
    t_rd_src  src;
    t_tile_id id;
    logic     oor;
  } t_rd_tag;

  localparam logic [31:0] DEAD_DATA         = 32'hDEAD_BEEF;
  localparam logic [31:0] D_MEM_OFFSET_MINI = 32'h0000_0000;
  localparam logic [31:0] D_MEM_MSB_MINI    = 32'h0000_3FFF;

  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] lo,
                                         input logic [31:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mini_dmem_arb_rsp_fifo.sv
// ============================================================================
// mini_dmem_rsp_fifo : synchronous {id, data} FIFO for fabric read responses
// Rev 1.0
// ============================================================================
`default_nettype none

module mini_dmem_rsp_fifo #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 8,
  parameter int DEPTH  = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ID_W-1:0]   push_id,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [ID_W-1:0]   head_id,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [ID_W+DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count_q;
  logic                   do_push;
  logic                   do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr] <= {push_id, push_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign count     = count_q;
  assign head_id   = mem_q[rd_ptr][ID_W+DATA_W-1:DATA_W];
  assign head_data = mem_q[rd_ptr][DATA_W-1:0];

endmodule

`default_nettype wire

// File: rtl/mini_dmem_arb.sv
// ============================================================================
// mini_dmem_arb : shares the D_MEM port between core and fabric requesters
// Rev 1.0
// ============================================================================
`default_nettype none

module mini_dmem_arb
  import mini_dmem_arb_pkg::*;
#(
  parameter int               ADDR_W       = 32,
  parameter int               DATA_W       = 32,
  parameter logic [ADDR_W-1:0] D_MEM_LSB   = ADDR_W'(D_MEM_OFFSET_MINI),
  parameter logic [ADDR_W-1:0] D_MEM_MSB   = ADDR_W'(D_MEM_MSB_MINI),
  parameter int               STARVE_LIMIT = 4,
  parameter int               RSP_DEPTH    = 2
) (
  input  logic              Clock,
  input  logic              Rst,
  input  logic              CoreReqValid,
  input  logic              CoreWrEn,
  input  logic [ADDR_W-1:0] CoreAddr,
  input  logic [DATA_W-1:0] CoreWrData,
  input  logic [3:0]        CoreByteEn,
  output logic              CoreStall,
  output logic              CoreRdValid,
  output logic [DATA_W-1:0] CoreRdData,
  input  logic              FabReqValid,
  input  logic              FabReqOpcode,
  input  logic [ADDR_W-1:0] FabAddr,
  input  logic [DATA_W-1:0] FabWrData,
  input  logic [3:0]        FabByteEn,
  input  logic [7:0]        FabReqId,
  output logic              FabReqReady,
  output logic              FabRspValid,
  output logic [DATA_W-1:0] FabRspData,
  output logic [7:0]        FabRspId,
  input  logic              FabRspReady,
  output logic              MemRdEn,
  output logic              MemWrEn,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWrData,
  output logic [3:0]        MemByteEn,
  input  logic [DATA_W-1:0] MemRdData
);

  localparam int               CNT_W      = $clog2(RSP_DEPTH) + 1;
  localparam int               STV_W      = 4;
  localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

  t_dmem_req         core_req;
  t_dmem_req         fab_req;
  t_dmem_req         mem_req;
  t_rd_tag           tag_q;
  t_rd_tag           tag_d;
  logic [STV_W-1:0]  starve_q;
  logic [CNT_W-1:0]  rsp_count;
  logic [CNT_W-1:0]  inflight;
  logic              rsp_push;
  logic              rsp_pop;
  logic              rsp_full;
  logic              rsp_empty;
  t_tile_id          rsp_head_id;
  logic [DATA_W-1:0] rsp_head_data;
  logic [DATA_W-1:0] rd_data;
  logic              credit_ok;
  logic              fab_eligible;
  logic              fab_grant;
  logic              core_grant;
  logic              req_oor;

  // At most one fabric read can be in the tag stage, so in-flight is 0 or 1.
  assign inflight     = CNT_W'(tag_q.valid && (tag_q.src == SRC_FAB));
  assign credit_ok    = !rsp_full && ((rsp_count + inflight) < CNT_W'(RSP_DEPTH));
  assign fab_eligible = Rst && FabReqValid &&
                        ((t_dmem_op'(FabReqOpcode) == DMEM_WR) || credit_ok);
  assign fab_grant    = fab_eligible && (!CoreReqValid || (starve_q == STARVE_MAX));
  assign core_grant   = Rst && CoreReqValid && !fab_grant;

  always_comb begin
    core_req        = '0;
    core_req.valid  = core_grant;
    core_req.op     = CoreWrEn ? DMEM_WR : DMEM_RD;
    core_req.addr   = CoreAddr;
    core_req.wrdata = CoreWrData;
    core_req.byteen = CoreByteEn;

    fab_req         = '0;
    fab_req.valid   = fab_grant;
    fab_req.op      = t_dmem_op'(FabReqOpcode);
    fab_req.addr    = FabAddr;
    fab_req.wrdata  = FabWrData;
    fab_req.byteen  = FabByteEn;
    fab_req.id      = FabReqId;

    mem_req         = fab_grant ? fab_req : core_req;
  end

  assign req_oor   = !addr_in_range(mem_req.addr, D_MEM_LSB, D_MEM_MSB);
  assign MemRdEn   = mem_req.valid && (mem_req.op == DMEM_RD) && !req_oor;
  assign MemWrEn   = mem_req.valid && (mem_req.op == DMEM_WR) && !req_oor;
  assign MemAddr   = mem_req.addr;
  assign MemWrData = mem_req.wrdata;
  assign MemByteEn = mem_req.byteen;

  assign CoreStall   = CoreReqValid && fab_grant;
  assign FabReqReady = fab_grant;

  // Out-of-range reads still get a tag so the requester sees a response.
  always_comb begin
    tag_d       = '0;
    tag_d.valid = mem_req.valid && (mem_req.op == DMEM_RD);
    tag_d.src   = fab_grant ? SRC_FAB : SRC_CORE;
    tag_d.id    = mem_req.id;
    tag_d.oor   = req_oor;
  end

  always_ff @(posedge Clock) begin
    if (!Rst) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Rst) begin
      starve_q <= '0;
    end else if (!FabReqValid || fab_grant) begin
      starve_q <= '0;
    end else if (fab_eligible && core_grant && (starve_q != STARVE_MAX)) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  assign rd_data     = tag_q.oor ? DATA_W'(DEAD_DATA) : MemRdData;
  assign CoreRdValid = tag_q.valid && (tag_q.src == SRC_CORE);
  assign CoreRdData  = CoreRdValid ? rd_data : '0;
  assign rsp_push    = tag_q.valid && (tag_q.src == SRC_FAB);
  assign rsp_pop     = FabRspReady && !rsp_empty;

  mini_dmem_rsp_fifo #(
    .DATA_W (DATA_W),
    .ID_W   (8),
    .DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (Clock),
    .rst_n     (Rst),
    .push      (rsp_push),
    .push_id   (tag_q.id),
    .push_data (rd_data),
    .pop       (rsp_pop),
    .head_id   (rsp_head_id),
    .head_data (rsp_head_data),
    .count     (rsp_count),
    .full      (rsp_full),
    .empty     (rsp_empty)
  );

  assign FabRspValid = !rsp_empty;
  assign FabRspData  = rsp_empty ? '0 : rsp_head_data;
  assign FabRspId    = rsp_empty ? '0 : rsp_head_id;

endmodule

`default_nettype wire

// File: tb/tb_mini_dmem_arb.sv
// ============================================================================
// tb_mini_dmem_arb : directed self-checking bench with a simple D_MEM model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mini_dmem_arb;

  logic        Clock = 1'b0;
  logic        Rst   = 1'b0;
  logic        CoreReqValid, CoreWrEn;
  logic [31:0] CoreAddr, CoreWrData;
  logic [3:0]  CoreByteEn;
  logic        CoreStall, CoreRdValid;
  logic [31:0] CoreRdData;
  logic        FabReqValid, FabReqOpcode;
  logic [31:0] FabAddr, FabWrData;
  logic [3:0]  FabByteEn;
  logic [7:0]  FabReqId;
  logic        FabReqReady, FabRspValid;
  logic [31:0] FabRspData;
  logic [7:0]  FabRspId;
  logic        FabRspReady;
  logic        MemRdEn, MemWrEn;
  logic [31:0] MemAddr, MemWrData;
  logic [3:0]  MemByteEn;
  logic [31:0] MemRdData;

  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

  mini_dmem_arb dut (
    .Clock(Clock), .Rst(Rst),
    .CoreReqValid(CoreReqValid), .CoreWrEn(CoreWrEn), .CoreAddr(CoreAddr),
    .CoreWrData(CoreWrData), .CoreByteEn(CoreByteEn), .CoreStall(CoreStall),
    .CoreRdValid(CoreRdValid), .CoreRdData(CoreRdData),
    .FabReqValid(FabReqValid), .FabReqOpcode(FabReqOpcode), .FabAddr(FabAddr),
    .FabWrData(FabWrData), .FabByteEn(FabByteEn), .FabReqId(FabReqId),
    .FabReqReady(FabReqReady), .FabRspValid(FabRspValid), .FabRspData(FabRspData),
    .FabRspId(FabRspId), .FabRspReady(FabRspReady),
    .MemRdEn(MemRdEn), .MemWrEn(MemWrEn), .MemAddr(MemAddr),
    .MemWrData(MemWrData), .MemByteEn(MemByteEn), .MemRdData(MemRdData)
  );

  // D_MEM model: 16 KiB, byte-enabled writes, read data one cycle after MemRdEn.
  logic [31:0] dmem [0:4095];
  logic [31:0] mem_rd_q    = 32'h0;
  logic        preloaded   = 1'b0;
  logic        oor_wr_seen = 1'b0;
  assign MemRdData = mem_rd_q;

  always @(posedge Clock) begin
    if (!preloaded) begin
      dmem[12'h000] <= 32'hA5A5_A5A5;
      dmem[12'h400] <= 32'h1234_5678;
      dmem[12'h440] <= 32'h0000_0000;
      dmem[12'h480] <= 32'h0000_0000;
      preloaded     <= 1'b1;
    end else begin
      if (MemWrEn) begin
        if (MemAddr > 32'h0000_3FFF) oor_wr_seen <= 1'b1;
        for (int b = 0; b < 4; b++) begin
          if (MemByteEn[b]) dmem[MemAddr[13:2]][8*b +: 8] <= MemWrData[8*b +: 8];
        end
      end
      if (MemRdEn) mem_rd_q <= dmem[MemAddr[13:2]];
    end
  end

  always @(negedge Clock) begin
    if (Rst && dut.rsp_push && dut.rsp_full) begin
      errors++;
      $display("FAIL fifo_push_when_full: push=1 full=1 required full=0");
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    CoreReqValid = 1'b0; CoreWrEn = 1'b0; CoreAddr = '0; CoreWrData = '0; CoreByteEn = '0;
    FabReqValid  = 1'b0; FabReqOpcode = 1'b0; FabAddr = '0; FabWrData = '0;
    FabByteEn    = '0;   FabReqId = '0;
  endtask

  task automatic core_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be);
    CoreReqValid = 1'b1; CoreWrEn = we; CoreAddr = a; CoreWrData = d; CoreByteEn = be;
  endtask

  task automatic fab_req(input logic op, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic [7:0] id);
    FabReqValid = 1'b1; FabReqOpcode = op; FabAddr = a; FabWrData = d;
    FabByteEn = be; FabReqId = id;
  endtask

  task automatic test_reset();
    idle();
    FabRspReady = 1'b0;
    Rst = 1'b0;
    step();
    core_req(1'b0, 32'h1000, 32'h0, 4'hF);
    fab_req(1'b0, 32'h1000, 32'h0, 4'hF, 8'h01);
    step();
    checks++;
    if ({CoreStall, CoreRdValid, FabReqReady, FabRspValid, MemRdEn, MemWrEn} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b required 000000",
               {CoreStall, CoreRdValid, FabReqReady, FabRspValid, MemRdEn, MemWrEn});
    end
    idle();
    Rst = 1'b1;
    #1;
    checks++;
    if ({CoreRdData, FabRspData, FabRspId} !== 72'h0) begin
      errors++;
      $display("FAIL reset_data: core=%h rsp=%h id=%h required all zero",
               CoreRdData, FabRspData, FabRspId);
    end
    step();
  endtask

  task automatic test_core_load();
    core_req(1'b0, 32'h1000, 32'h0, 4'hF);
    #1;
    checks++;
    if ({CoreStall, MemRdEn, MemWrEn, MemAddr} !== {3'b010, 32'h1000}) begin
      errors++;
      $display("FAIL core_load_req: stall=%b rd=%b wr=%b addr=%h required 0 1 0 00001000",
               CoreStall, MemRdEn, MemWrEn, MemAddr);
    end
    step();
    idle();
    #1;
    checks++;
    if ({CoreRdValid, CoreRdData} !== {1'b1, 32'h1234_5678}) begin
      errors++;
      $display("FAIL core_load_data: valid=%b data=%h required 1 12345678", CoreRdValid, CoreRdData);
    end
    step();
    core_req(1'b1, 32'h1200, 32'hAABB_CCDD, 4'b0101);
    #1;
    checks++;
    if ({CoreRdValid, MemWrEn, MemRdEn, MemByteEn} !== 7'b0_1_0_0101) begin
      errors++;
      $display("FAIL core_store_req: rdvalid=%b wr=%b rd=%b be=%b required 0 1 0 0101",
               CoreRdValid, MemWrEn, MemRdEn, MemByteEn);
    end
    step();
    core_req(1'b0, 32'h1200, 32'h0, 4'hF);
    step();
    idle();
    #1;
    checks++;
    if ({CoreRdValid, CoreRdData} !== {1'b1, 32'h00BB_00DD}) begin
      errors++;
      $display("FAIL core_store_bytes: valid=%b data=%h required 1 00bb00dd", CoreRdValid, CoreRdData);
    end
    step();
  endtask

  task automatic test_starve();
    core_req(1'b0, 32'h1000, 32'h0, 4'hF);
    fab_req(1'b1, 32'h1100, 32'hCAFE_F00D, 4'hF, 8'h11);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (i < 4) begin
        if ({FabReqReady, CoreStall, MemRdEn} !== 3'b001) begin
          errors++;
          $display("FAIL starve_core_wins[%0d]: ready=%b stall=%b rd=%b required 0 0 1",
                   i, FabReqReady, CoreStall, MemRdEn);
        end
      end else begin
        if ({FabReqReady, CoreStall, MemWrEn, MemRdEn, MemAddr} !== {4'b1110, 32'h1100}) begin
          errors++;
          $display("FAIL starve_fab_grant: ready=%b stall=%b wr=%b rd=%b addr=%h required 1 1 1 0 00001100",
                   FabReqReady, CoreStall, MemWrEn, MemRdEn, MemAddr);
        end
      end
      step();
    end
    idle();
    core_req(1'b0, 32'h1100, 32'h0, 4'hF);
    #1;
    checks++;
    if ({CoreStall, CoreRdValid} !== 2'b00) begin
      errors++;
      $display("FAIL starve_after_grant: stall=%b rdvalid=%b required 0 0", CoreStall, CoreRdValid);
    end
    step();
    idle();
    #1;
    checks++;
    if ({CoreRdValid, CoreRdData} !== {1'b1, 32'hCAFE_F00D}) begin
      errors++;
      $display("FAIL starve_write_visible: valid=%b data=%h required 1 cafef00d", CoreRdValid, CoreRdData);
    end
    step();
  endtask

  task automatic test_backpressure();
    FabRspReady = 1'b0;
    fab_req(1'b0, 32'h1000, 32'h0, 4'hF, 8'h01);
    #1;
    checks++;
    if ({FabReqReady, MemRdEn} !== 2'b11) begin
      errors++;
      $display("FAIL bp_first_read: ready=%b rd=%b required 1 1", FabReqReady, MemRdEn);
    end
    step();
    fab_req(1'b0, 32'h1100, 32'h0, 4'hF, 8'h02);
    #1;
    checks++;
    if (FabReqReady !== 1'b1) begin
      errors++;
      $display("FAIL bp_second_read: ready=%b required 1", FabReqReady);
    end
    step();
    fab_req(1'b0, 32'h1000, 32'h0, 4'hF, 8'h03);
    #1;
    checks++;
    if ({FabReqReady, MemRdEn, FabRspValid, FabRspId, FabRspData} !== {3'b001, 8'h01, 32'h1234_5678}) begin
      errors++;
      $display("FAIL bp_third_blocked: ready=%b rd=%b rspv=%b id=%h data=%h required 0 0 1 01 12345678",
               FabReqReady, MemRdEn, FabRspValid, FabRspId, FabRspData);
    end
    step();
    FabRspReady = 1'b1;
    #1;
    checks++;
    if ({FabReqReady, FabRspValid, FabRspId} !== {2'b01, 8'h01}) begin
      errors++;
      $display("FAIL bp_full_hold: ready=%b rspv=%b id=%h required 0 1 01", FabReqReady, FabRspValid, FabRspId);
    end
    step();
    #1;
    checks++;
    if ({FabReqReady, FabRspId, FabRspData} !== {1'b1, 8'h02, 32'hCAFE_F00D}) begin
      errors++;
      $display("FAIL bp_after_pop: ready=%b id=%h data=%h required 1 02 cafef00d",
               FabReqReady, FabRspId, FabRspData);
    end
    step();
    idle();
    FabRspReady = 1'b0;
    #1;
    checks++;
    if (FabRspValid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drained: rspv=%b required 0", FabRspValid);
    end
    step();
    #1;
    checks++;
    if ({FabRspValid, FabRspId, FabRspData} !== {1'b1, 8'h03, 32'h1234_5678}) begin
      errors++;
      $display("FAIL bp_third_rsp: rspv=%b id=%h data=%h required 1 03 12345678",
               FabRspValid, FabRspId, FabRspData);
    end
    FabRspReady = 1'b1;
    step();
    FabRspReady = 1'b0;
    step();
  endtask

  task automatic test_push_pop_same();
    FabRspReady = 1'b0;
    fab_req(1'b0, 32'h1000, 32'h0, 4'hF, 8'h22);
    step();
    fab_req(1'b0, 32'h1100, 32'h0, 4'hF, 8'h23);
    step();
    idle();
    FabRspReady = 1'b1;
    #1;
    checks++;
    if ({FabRspValid, FabRspId, FabRspData, dut.rsp_count} !== {1'b1, 8'h22, 32'h1234_5678, 2'd1}) begin
      errors++;
      $display("FAIL pp_first: rspv=%b id=%h data=%h count=%0d required 1 22 12345678 1",
               FabRspValid, FabRspId, FabRspData, dut.rsp_count);
    end
    step();
    #1;
    checks++;
    if ({FabRspValid, FabRspId, FabRspData, dut.rsp_count} !== {1'b1, 8'h23, 32'hCAFE_F00D, 2'd1}) begin
      errors++;
      $display("FAIL pp_same_cycle: rspv=%b id=%h data=%h count=%0d required 1 23 cafef00d 1",
               FabRspValid, FabRspId, FabRspData, dut.rsp_count);
    end
    step();
    FabRspReady = 1'b0;
    #1;
    checks++;
    if (FabRspValid !== 1'b0) begin
      errors++;
      $display("FAIL pp_empty: rspv=%b required 0", FabRspValid);
    end
    step();
  endtask

  task automatic test_out_of_range();
    FabRspReady = 1'b0;
    fab_req(1'b0, 32'h4000, 32'h0, 4'hF, 8'h5A);
    #1;
    checks++;
    if ({FabReqReady, MemRdEn} !== 2'b10) begin
      errors++;
      $display("FAIL oor_read_req: ready=%b rd=%b required 1 0", FabReqReady, MemRdEn);
    end
    step();
    idle();
    #1;
    checks++;
    if (FabRspValid !== 1'b0) begin
      errors++;
      $display("FAIL oor_rsp_early: rspv=%b required 0", FabRspValid);
    end
    step();
    checks++;
    if ({FabRspValid, FabRspId, FabRspData} !== {1'b1, 8'h5A, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL oor_rsp: rspv=%b id=%h data=%h required 1 5a deadbeef",
               FabRspValid, FabRspId, FabRspData);
    end
    FabRspReady = 1'b1;
    step();
    FabRspReady = 1'b0;
    fab_req(1'b1, 32'h4000, 32'h1111_1111, 4'hF, 8'h5B);
    #1;
    checks++;
    if ({FabReqReady, MemWrEn} !== 2'b10) begin
      errors++;
      $display("FAIL oor_write_req: ready=%b wr=%b required 1 0", FabReqReady, MemWrEn);
    end
    step();
    idle();
    core_req(1'b0, 32'h4000, 32'h0, 4'hF);
    #1;
    checks++;
    if ({MemRdEn, oor_wr_seen, dmem[12'h000]} !== {2'b00, 32'hA5A5_A5A5}) begin
      errors++;
      $display("FAIL oor_write_dropped: rd=%b oorwr=%b mem0=%h required 0 0 a5a5a5a5",
               MemRdEn, oor_wr_seen, dmem[12'h000]);
    end
    step();
    idle();
    #1;
    checks++;
    if ({CoreRdValid, CoreRdData} !== {1'b1, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL oor_core_read: valid=%b data=%h required 1 deadbeef", CoreRdValid, CoreRdData);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    FabRspReady = 1'b0;
    fab_req(1'b0, 32'h1000, 32'h0, 4'hF, 8'h77);
    #1;
    checks++;
    if (FabReqReady !== 1'b1) begin
      errors++;
      $display("FAIL rm_grant: ready=%b required 1", FabReqReady);
    end
    step();
    idle();
    Rst = 1'b0;
    step();
    Rst = 1'b1;
    #1;
    checks++;
    if ({CoreStall, CoreRdValid, FabReqReady, FabRspValid, MemRdEn, MemWrEn,
         CoreRdData, FabRspData, FabRspId, dut.rsp_count} !== {6'b0, 72'h0, 2'd0}) begin
      errors++;
      $display("FAIL rm_outputs: flags=%b core=%h rsp=%h id=%h count=%0d required all zero",
               {CoreStall, CoreRdValid, FabReqReady, FabRspValid, MemRdEn, MemWrEn},
               CoreRdData, FabRspData, FabRspId, dut.rsp_count);
    end
    for (int i = 0; i < 4; i++) begin
      if (FabRspValid) seen++;
      step();
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rm_no_response: rspv cycles=%0d required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_core_load();
    test_starve();
    test_backpressure();
    test_push_pop_same();
    test_out_of_range();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
